cpu_control_unit: RTL and testbench

//  Multi-cycle control/operand stage directly upstream of the 8-bit ALU.

---
 rtl/cpu_control_unit_pkg.sv | 51 +++++
 rtl/cpu_control_unit_reg_file.sv | 36 +++
 rtl/cpu_control_unit.sv | 125 ++++++++++++
 tb/tb_cpu_control_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_unit_pkg.sv
// CPU control-stage definitions: opcodes, ALU select codes, instruction
// field layout, FSM states and the opcode decoder.
package cpu_control_unit_pkg;

  localparam int FIELD_W  = 8;
  localparam int OPC_LSB  = 24;
  localparam int DST_LSB  = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] sel;
    logic       use_imm;  // DATA2 comes from the immediate field
    logic       negate;   // DATA2 is the two's complement of src2 (sub)
  } dec_t;

  function automatic dec_t decode(input logic [7:0] opc);
    dec_t d;
    d = '{legal: 1'b1, sel: ALU_ADD, use_imm: 1'b0, negate: 1'b0};
    case (opc)
      OP_LOADI: begin d.sel = ALU_FWD; d.use_imm = 1'b1; end
      OP_MOV:   d.sel = ALU_FWD;
      OP_ADD:   d.sel = ALU_ADD;
      OP_SUB:   begin d.sel = ALU_ADD; d.negate = 1'b1; end
      OP_AND:   d.sel = ALU_AND;
      OP_OR:    d.sel = ALU_OR;
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_control_unit_reg_file.sv
// Architectural register file: two async operand reads, async debug read,
// one synchronous write port, synchronous clear.
module cpu_control_unit_reg_file #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  assign rdata1   = mem[raddr1];
  assign rdata2   = mem[raddr2];
  assign dbg_data = mem[dbg_addr];

  // Reset clears every register and takes priority over a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control/operand stage in front of the 8-bit ALU: accepts one
// instruction, drives held ALU operands, waits for settle, writes back.
module cpu_control_unit
  import cpu_control_unit_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ALU_WAIT = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTR,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  output logic [DATA_W-1:0] ALU_DATA1,
  output logic [DATA_W-1:0] ALU_DATA2,
  output logic [2:0]        ALU_SELECT,
  input  logic [DATA_W-1:0] ALU_RESULT,
  output logic              DONE,
  output logic              ILLEGAL,
  input  logic [2:0]        DBG_ADDR,
  output logic [DATA_W-1:0] DBG_DATA
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     dest_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] rdata1, rdata2, op2;
  logic [FIELD_W-1:0] opc, imm;
  logic [AW-1:0]     dst_a, src1_a, src2_a;
  logic              we;
  dec_t              dec;
  logic              unused_fields;

  assign opc    = INSTR[OPC_LSB +: FIELD_W];
  assign imm    = INSTR[SRC2_LSB +: FIELD_W];
  assign dst_a  = INSTR[DST_LSB +: AW];
  assign src1_a = INSTR[SRC1_LSB +: AW];
  assign src2_a = INSTR[SRC2_LSB +: AW];
  // Upper bits of the register fields carry no address information.
  assign unused_fields = ^{INSTR[DST_LSB+AW +: FIELD_W-AW], INSTR[SRC1_LSB+AW +: FIELD_W-AW]};

  assign INSTR_READY = (state == ST_IDLE);
  // Illegal instructions reach WB with ILLEGAL set and must not write.
  assign we = (state == ST_WB) && !ILLEGAL;

  cpu_control_unit_reg_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .AW(AW)) u_rf (
    .clk      (CLK),
    .rst      (RESET),
    .we       (we),
    .waddr    (dest_q),
    .wdata    (result_q),
    .raddr1   (src1_a),
    .rdata1   (rdata1),
    .raddr2   (src2_a),
    .rdata2   (rdata2),
    .dbg_addr (DBG_ADDR),
    .dbg_data (DBG_DATA)
  );

  // Operand mux: immediate, src2, or negated src2 so sub runs on the adder.
  always_comb begin
    dec = decode(opc);
    op2 = rdata2;
    if (dec.use_imm)     op2 = DATA_W'(imm);
    else if (dec.negate) op2 = -rdata2;
  end

  // Control FSM; ALU operands only change on a legal accept so the ALU
  // never sees glitches between instructions.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dest_q     <= '0;
      result_q   <= '0;
      ALU_DATA1  <= '0;
      ALU_DATA2  <= '0;
      ALU_SELECT <= ALU_FWD;
      DONE       <= 1'b0;
      ILLEGAL    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          DONE    <= 1'b0;
          ILLEGAL <= 1'b0;
          if (INSTR_VALID) begin
            dest_q <= dst_a;
            if (dec.legal) begin
              ALU_DATA1  <= rdata1;
              ALU_DATA2  <= op2;
              ALU_SELECT <= dec.sel;
              cnt        <= CW'(ALU_WAIT - 1);
              state      <= ST_EXEC;
            end else begin
              DONE    <= 1'b1;
              ILLEGAL <= 1'b1;
              state   <= ST_WB;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            result_q <= ALU_RESULT;
            DONE     <= 1'b1;
            state    <= ST_WB;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WB: begin
          DONE    <= 1'b0;
          ILLEGAL <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: environment ALU, architectural reference
// model, per-cycle compare plus literal checks for the directed scenarios.
module tb_cpu_control_unit;

  localparam int ALU_WAIT = 2;

  logic        CLK = 1'b0;
  logic        RESET, INSTR_VALID, INSTR_READY, DONE, ILLEGAL;
  logic [31:0] INSTR;
  logic [7:0]  ALU_DATA1, ALU_DATA2, ALU_RESULT, DBG_DATA;
  logic [2:0]  ALU_SELECT, DBG_ADDR;

  cpu_control_unit #(.DATA_W(8), .NUM_REGS(8), .ALU_WAIT(ALU_WAIT)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2),
    .ALU_SELECT(ALU_SELECT), .ALU_RESULT(ALU_RESULT), .DONE(DONE),
    .ILLEGAL(ILLEGAL), .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
  );

  always #5 CLK = ~CLK;

  // The downstream ALU.
  always_comb begin
    ALU_RESULT = 8'h00;
    case (ALU_SELECT)
      3'b000: ALU_RESULT = ALU_DATA2;
      3'b001: ALU_RESULT = ALU_DATA1 + ALU_DATA2;
      3'b010: ALU_RESULT = ALU_DATA1 & ALU_DATA2;
      3'b011: ALU_RESULT = ALU_DATA1 | ALU_DATA2;
      default: ALU_RESULT = 8'h00;
    endcase
  end

  // Reference model state (architectural registers + retire countdown).
  logic [7:0] mreg [8];
  int         left;
  logic       m_legal;
  logic [2:0] m_dst;
  logic [7:0] m_res;
  logic [2:0] e_sel;
  logic [7:0] e_d1, e_d2;
  logic       e_done, e_ill, e_rdy;
  bit         model_ok;
  int         n_cmp, n_bad, cyc;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // One clock edge of the architectural model, using the inputs this bench drives.
  task automatic model_step();
    logic [7:0] op, a, b, imm;
    if (RESET) begin
      for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
      left = 0; m_legal = 1'b1; e_sel = 3'b000; e_d1 = 8'h00; e_d2 = 8'h00;
      model_ok = 1'b1;
    end else if (left > 0) begin
      left--;
      if (left == 0 && m_legal) mreg[m_dst] = m_res;
    end else if (INSTR_VALID) begin
      op = INSTR[31:24]; m_dst = INSTR[18:16];
      a = mreg[INSTR[10:8]]; b = mreg[INSTR[2:0]]; imm = INSTR[7:0];
      m_legal = 1'b1;
      case (op)
        8'h00: begin e_sel = 3'b000; e_d2 = imm;     m_res = imm;   end
        8'h01: begin e_sel = 3'b000; e_d2 = b;       m_res = b;     end
        8'h02: begin e_sel = 3'b001; e_d2 = b;       m_res = a + b; end
        8'h03: begin e_sel = 3'b001; e_d2 = 8'h00 - b; m_res = a - b; end
        8'h04: begin e_sel = 3'b010; e_d2 = b;       m_res = a & b; end
        8'h05: begin e_sel = 3'b011; e_d2 = b;       m_res = a | b; end
        default: m_legal = 1'b0;
      endcase
      if (m_legal) begin e_d1 = a; left = ALU_WAIT + 1; end
      else left = 1;
    end
    e_rdy  = (left == 0);
    e_done = (left == 1);
    e_ill  = e_done && !m_legal;
  endtask

  // One cycle: model at the rising edge, compare at the falling edge.
  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    if (model_ok) begin
      chk("ready",   INSTR_READY, e_rdy);
      chk("done",    DONE,        e_done);
      chk("illegal", ILLEGAL,     e_ill);
      chk("select",  ALU_SELECT,  e_sel);
      chk("data1",   ALU_DATA1,   e_d1);
      chk("data2",   ALU_DATA2,   e_d2);
      chk("dbg",     DBG_DATA,    mreg[DBG_ADDR]);
    end
    cyc++;
    #1;
    DBG_ADDR = DBG_ADDR + 3'd1;
  endtask

  task automatic dbg_lit(input string nm, input logic [2:0] addr, input logic [7:0] exp);
    DBG_ADDR = addr;
    #1;
    chk(nm, DBG_DATA, exp);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50 && !INSTR_READY; n++) tick();
    chk("idle_timeout", INSTR_READY, 1);
  endtask

  // Present one instruction until accepted; returns in the cycle after the accept edge.
  task automatic issue(input logic [31:0] ins);
    logic acc;
    acc = 1'b0;
    INSTR = ins; INSTR_VALID = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = INSTR_READY;
      tick();
    end
    chk("accept", acc, 1);
    INSTR_VALID = 1'b0;
    INSTR = $urandom;
  endtask

  task automatic issue3(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2);
    logic [31:0] q [3];
    int acc_cyc [3];
    int idx;
    logic acc;
    q[0] = i0; q[1] = i1; q[2] = i2;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    idx = 0;
    INSTR = q[0]; INSTR_VALID = 1'b1;
    for (int n = 0; n < 100 && idx < 3; n++) begin
      acc = INSTR_READY;
      tick();
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) INSTR = q[idx];
      end
    end
    INSTR_VALID = 1'b0;
    chk("q_count",   32'(idx), 3);
    chk("q_period1", 32'(acc_cyc[1] - acc_cyc[0]), ALU_WAIT + 2);
    chk("q_period2", 32'(acc_cyc[2] - acc_cyc[1]), ALU_WAIT + 2);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; model_ok = 1'b0; left = 0;
    RESET = 1'b1; INSTR_VALID = 1'b0; INSTR = 32'h0; DBG_ADDR = 3'd0;
    tick(); tick();
    chk("rst_ready", INSTR_READY, 1);
    chk("rst_sel",   ALU_SELECT, 0);
    chk("rst_d1",    ALU_DATA1, 0);
    chk("rst_d2",    ALU_DATA2, 0);
    chk("rst_done",  {DONE, ILLEGAL}, 0);
    dbg_lit("rst_r3", 3'd3, 8'h00);
    RESET = 1'b0;

    // loadi r1,5; loadi r2,3; add r3,r1,r2
    issue(32'h00_01_00_05); wait_idle();
    issue(32'h00_02_00_03); wait_idle();
    issue(32'h02_03_01_02);
    chk("add_sel", ALU_SELECT, 3'b001);
    chk("add_d1",  ALU_DATA1, 8'h05);
    chk("add_d2",  ALU_DATA2, 8'h03);
    wait_idle();
    dbg_lit("add_r3", 3'd3, 8'h08);

    // sub r4,r2,r1 = 3-5; wraparound add FF+01
    issue(32'h03_04_02_01);
    chk("sub_sel", ALU_SELECT, 3'b001);
    chk("sub_d2",  ALU_DATA2, 8'hFB);
    wait_idle();
    dbg_lit("sub_r4", 3'd4, 8'hFE);
    issue(32'h00_05_00_FF); wait_idle();
    issue(32'h00_06_00_01); wait_idle();
    issue(32'h02_07_05_06); wait_idle();
    dbg_lit("wrap_r7", 3'd7, 8'h00);

    // logic ops and mov
    issue(32'h00_01_00_D5); wait_idle();
    issue(32'h00_02_00_EA); wait_idle();
    issue(32'h04_03_01_02); wait_idle();
    dbg_lit("and_r3", 3'd3, 8'hC0);
    issue(32'h05_03_01_02); wait_idle();
    dbg_lit("or_r3", 3'd3, 8'hFF);
    issue(32'h01_00_00_01);
    chk("mov_sel", ALU_SELECT, 3'b000);
    wait_idle();
    dbg_lit("mov_r0", 3'd0, 8'hD5);

    // illegal opcode 07
    issue(32'h07_03_01_02);
    chk("ill_done",  {DONE, ILLEGAL}, 2'b11);
    chk("ill_sel",   ALU_SELECT, 3'b000);
    chk("ill_d2",    ALU_DATA2, 8'hD5);
    tick();
    chk("ill_pulse", {DONE, ILLEGAL, INSTR_READY}, 3'b001);
    dbg_lit("ill_r3", 3'd3, 8'hFF);

    // back-to-back with VALID held, including RAW through r1
    issue3(32'h00_01_00_05, 32'h02_01_01_01, 32'h02_02_01_01);
    wait_idle();
    dbg_lit("q_r1", 3'd1, 8'h0A);
    dbg_lit("q_r2", 3'd2, 8'h14);

    // reset during EXEC aborts the instruction
    issue(32'h00_01_00_07);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("abort_ready", INSTR_READY, 1);
    chk("abort_done",  DONE, 0);
    dbg_lit("abort_r1", 3'd1, 8'h00);
    repeat (5) tick();
    dbg_lit("abort_r1_late", 3'd1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
